// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile
//   I2C target on an open-drain SCL/SDA bus. It holds a 16x8 register file
//   reached through a 4-bit pointer. A write transfer loads the pointer and then
//   data bytes. A read transfer returns the addressed bytes. SCL is never driven.
//
// Ports
//   HCLK       system clock
//   HRESET     synchronous reset, active-high
//   scl_i      SCL pad level (asynchronous)
//   sda_i      SDA pad level (asynchronous)
//   sda_oe     1 = pull SDA low
//   wr_pulse   one-cycle strobe when an I2C write updates a register
//   wr_idx     index of that write
//   wr_data    byte of that write
//   loc_idx    local peek index
//   loc_rdata  regfile[loc_idx], combinational
//   busy       addressed transfer in progress
//
// Build option: I2CT_AUTOINC_EN
//   Defined: the pointer advances after each data byte and wraps F -> 0.
//   Undefined: the pointer is held.
//
// state       | meaning
// ------------+----------------------------------------------------------
// S_IDLE      | bus ignored until START
// S_ADDR      | shifting the address byte
// S_ADDR_ACK  | ACKing the address, then branching on R/W
// S_PTR       | shifting and ACKing the pointer byte
// S_WDATA     | shifting, storing and ACKing data bytes
// S_RDATA     | driving regs[ptr], sampling the master ACK
// S_WAIT_STOP | master NACKed; SDA released until STOP or START

module i2c_target_regfile #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         FILT_LEN = 3
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       wr_pulse,
    output logic [3:0] wr_idx,
    output logic [7:0] wr_data,
    input  logic [3:0] loc_idx,
    output logic [7:0] loc_rdata,
    output logic       busy
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_WDATA, S_RDATA, S_WAIT_STOP
    } state_t;

    // Write side: ACK_WAIT = byte taken, pull low on the next fall;
    //             ACK_HOLD = pulling low, release on the 9th fall.
    // Read side:  ACK_WAIT = released, sample master ACK on the 9th rise;
    //             ACK_HOLD = ACK seen, load the next byte on the 9th fall.
    typedef enum logic [1:0] {PH_BITS, PH_ACK_WAIT, PH_ACK_HOLD} phase_t;

    // Index 0 is SCL, index 1 is SDA.
    logic [1:0]    sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]    filt_q, filt_d, prev_q, prev_d;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  shreg_q, shreg_d;
    logic        rw_q, rw_d;
    logic [3:0]  ptr_q, ptr_d;
    logic        busy_q, busy_d;
    logic        sda_oe_q, sda_oe_d;
    logic        wr_pulse_q, wr_pulse_d;
    logic [3:0]  wr_idx_q, wr_idx_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [7:0]  regs_q [16];
    logic [7:0]  regs_d [16];

    logic       scl_f, sda_f, scl_rise, scl_fall, start_ev, stop_ev;
    logic [7:0] byte_in;
    logic [3:0] ptr_inc;

`ifdef I2CT_AUTOINC_EN
    assign ptr_inc = ptr_q + 4'd1;
`else
    assign ptr_inc = ptr_q;
`endif

    always_comb begin
        sync1_d = {sda_i, scl_i};
        sync2_d = sync1_q;
        prev_d  = filt_q;
        filt_d  = filt_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (cnt_q[i] == CNT_MAX) filt_d[i] = sync2_q[i];
                else                     cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    assign scl_f    = filt_q[0];
    assign sda_f    = filt_q[1];
    assign scl_rise = scl_f & ~prev_q[0];
    assign scl_fall = ~scl_f & prev_q[0];
    assign start_ev = scl_f & prev_q[0] & prev_q[1] & ~sda_f;
    assign stop_ev  = scl_f & prev_q[0] & ~prev_q[1] & sda_f;
    assign byte_in  = {shreg_q, sda_f};

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        rw_d       = rw_q;
        ptr_d      = ptr_q;
        busy_d     = busy_q;
        sda_oe_d   = sda_oe_q;
        wr_pulse_d = 1'b0;
        wr_idx_d   = wr_idx_q;
        wr_data_d  = wr_data_q;
        regs_d     = regs_q;

        if (stop_ev) begin
            state_d   = S_IDLE;
            phase_d   = PH_BITS;
            bit_cnt_d = '0;
            busy_d    = 1'b0;
            sda_oe_d  = 1'b0;
        end else if (start_ev) begin
            // The pointer is kept so a repeated-START read follows a pointer write.
            state_d   = S_ADDR;
            phase_d   = PH_BITS;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: ;
                S_ADDR: begin
                    if (scl_rise) begin
                        shreg_d   = byte_in[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (byte_in[7:1] == DEV_ADDR) begin
                                state_d = S_ADDR_ACK;
                                phase_d = PH_ACK_WAIT;
                                rw_d    = byte_in[0];
                                busy_d  = 1'b1;
                            end else begin
                                state_d = S_IDLE;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                S_ADDR_ACK, S_PTR, S_WDATA: begin
                    if (phase_q == PH_BITS) begin
                        if (scl_rise) begin
                            shreg_d   = byte_in[6:0];
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                phase_d = PH_ACK_WAIT;
                                if (state_q == S_PTR) begin
                                    ptr_d = byte_in[3:0];
                                end else begin
                                    regs_d[ptr_q] = byte_in;
                                    wr_pulse_d    = 1'b1;
                                    wr_idx_d      = ptr_q;
                                    wr_data_d     = byte_in;
                                    ptr_d         = ptr_inc;
                                end
                            end
                        end
                    end else if (scl_fall) begin
                        if (phase_q == PH_ACK_WAIT) begin
                            sda_oe_d = 1'b1;
                            phase_d  = PH_ACK_HOLD;
                        end else begin
                            sda_oe_d  = 1'b0;
                            phase_d   = PH_BITS;
                            bit_cnt_d = '0;
                            if (state_q == S_ADDR_ACK) begin
                                if (rw_q) begin
                                    // First read bit goes out on the same fall that ends the ACK.
                                    state_d  = S_RDATA;
                                    shreg_d  = regs_q[ptr_q][6:0];
                                    sda_oe_d = ~regs_q[ptr_q][7];
                                end else begin
                                    state_d = S_PTR;
                                end
                            end else begin
                                state_d = S_WDATA;
                            end
                        end
                    end
                end
                S_RDATA: begin
                    case (phase_q)
                        PH_BITS: if (scl_fall) begin
                            if (bit_cnt_q == 3'd7) begin
                                sda_oe_d  = 1'b0;
                                phase_d   = PH_ACK_WAIT;
                                bit_cnt_d = '0;
                            end else begin
                                bit_cnt_d = bit_cnt_q + 3'd1;
                                sda_oe_d  = ~shreg_q[6];
                                shreg_d   = {shreg_q[5:0], 1'b0};
                            end
                        end
                        PH_ACK_WAIT: if (scl_rise) begin
                            if (!sda_f) begin
                                ptr_d   = ptr_inc;
                                phase_d = PH_ACK_HOLD;
                            end else begin
                                state_d = S_WAIT_STOP;
                                phase_d = PH_BITS;
                            end
                        end
                        default: if (scl_fall) begin
                            shreg_d   = regs_q[ptr_q][6:0];
                            sda_oe_d  = ~regs_q[ptr_q][7];
                            bit_cnt_d = '0;
                            phase_d   = PH_BITS;
                        end
                    endcase
                end
                S_WAIT_STOP: sda_oe_d = 1'b0;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            // Line state resets to the idle-high bus level so no false edge is seen.
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            filt_q     <= 2'b11;
            prev_q     <= 2'b11;
            cnt_q[0]   <= '0;
            cnt_q[1]   <= '0;
            state_q    <= S_IDLE;
            phase_q    <= PH_BITS;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            rw_q       <= 1'b0;
            ptr_q      <= '0;
            busy_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_idx_q   <= '0;
            wr_data_q  <= '0;
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            filt_q     <= filt_d;
            prev_q     <= prev_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            rw_q       <= rw_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            sda_oe_q   <= sda_oe_d;
            wr_pulse_q <= wr_pulse_d;
            wr_idx_q   <= wr_idx_d;
            wr_data_q  <= wr_data_d;
            regs_q     <= regs_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign wr_pulse  = wr_pulse_q;
    assign wr_idx    = wr_idx_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign loc_rdata = regs_q[loc_idx];

endmodule

// File: tb/tb_i2c_target_regfile.sv
`timescale 1ns/1ps
module tb_i2c_target_regfile;

    // SCL quarter period in HCLK cycles (one bit = 4 quarters).
    localparam int TQ = 30;

    logic       HCLK = 1'b0;
    logic       HRESET;
    logic       scl_i, sda_i, sda_oe, wr_pulse, busy;
    logic [3:0] wr_idx, loc_idx;
    logic [7:0] wr_data, loc_rdata;
    logic       m_scl, m_sda;

    int checks = 0;
    int errors = 0;

    logic [11:0] wr_q [$];
    logic [7:0]  rd_q [$];
    logic [7:0]  model_regs [16];
    logic [3:0]  m_ptr;
    logic        oe_seen, busy_seen;

    always #10 HCLK = ~HCLK;

    assign scl_i = m_scl;
    assign sda_i = m_sda & ~sda_oe;

    i2c_target_regfile #(.DEV_ADDR(7'h50), .FILT_LEN(3)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .scl_i(scl_i), .sda_i(sda_i),
        .sda_oe(sda_oe), .wr_pulse(wr_pulse), .wr_idx(wr_idx), .wr_data(wr_data),
        .loc_idx(loc_idx), .loc_rdata(loc_rdata), .busy(busy)
    );

    always @(negedge HCLK) begin
        if (sda_oe === 1'b1) oe_seen = 1'b1;
        if (busy === 1'b1) busy_seen = 1'b1;
        if (HRESET === 1'b0 && wr_pulse === 1'b1) begin
            logic [11:0] exp;
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: got idx=%0h data=%02h, required no write", wr_idx, wr_data);
            end else begin
                exp = wr_q.pop_front();
                if ({wr_idx, wr_data} !== exp) begin
                    errors++;
                    $display("FAIL wr_event: got idx=%0h data=%02h, required idx=%0h data=%02h",
                             wr_idx, wr_data, exp[11:8], exp[7:0]);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] nxt(input logic [3:0] p);
`ifdef I2CT_AUTOINC_EN
        return p + 4'd1;
`else
        return p;
`endif
    endfunction

    task automatic tq();
        repeat (TQ) @(negedge HCLK);
    endtask

    task automatic i2c_start();
        if (m_scl == 1'b0) begin
            m_sda = 1'b1; tq();
            m_scl = 1'b1; tq();
        end
        m_sda = 1'b0; tq();
        m_scl = 1'b0; tq();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; tq();
        m_scl = 1'b1; tq();
        m_sda = 1'b1; tq(); tq();
    endtask

    task automatic clk_bit(input logic v, output logic s);
        m_sda = v; tq();
        m_scl = 1'b1; tq();
        s = sda_i; tq();
        m_scl = 1'b0; tq();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(1'b1, b[i]);
        clk_bit(mack, s);
    endtask

    task automatic send_data(input logic [7:0] d, output logic ack);
        wr_q.push_back({m_ptr, d});
        model_regs[m_ptr] = d;
        m_ptr = nxt(m_ptr);
        write_byte(d, ack);
    endtask

    task automatic test_reset();
        HRESET = 1'b1; m_scl = 1'b1; m_sda = 1'b1; loc_idx = 4'd0;
        repeat (5) @(negedge HCLK);
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rst_sda_oe: got %b, required 0", sda_oe); end
        checks++; if (wr_pulse !== 1'b0) begin errors++; $display("FAIL rst_wr_pulse: got %b, required 0", wr_pulse); end
        checks++; if (wr_idx !== 4'h0) begin errors++; $display("FAIL rst_wr_idx: got %0h, required 0", wr_idx); end
        checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL rst_wr_data: got %02h, required 00", wr_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
        for (int i = 0; i < 16; i++) begin
            loc_idx = 4'(i); #1;
            checks++;
            if (loc_rdata !== 8'h00) begin errors++; $display("FAIL rst_reg[%0d]: got %02h, required 00", i, loc_rdata); end
            model_regs[i] = 8'h00;
        end
        m_ptr = 4'd0;
        @(negedge HCLK); HRESET = 1'b0;
        repeat (10) @(negedge HCLK);
    endtask

    task automatic test_write();
        logic ack;
        i2c_start();
        write_byte(8'hA0, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_addr_ack: got %b, required 0", ack); end
        write_byte(8'h03, ack); m_ptr = 4'h3;
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_ptr_ack: got %b, required 0", ack); end
        send_data(8'hA5, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_data_ack: got %b, required 0", ack); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy_mid: got %b, required 1", busy); end
        i2c_stop();
        repeat (20) @(negedge HCLK);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_after: got %b, required 0", busy); end
        checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL wr_missing: got %0d pending, required 0", wr_q.size()); end
        loc_idx = 4'h3; #1;
        checks++; if (loc_rdata !== 8'hA5) begin errors++; $display("FAIL wr_reg3: got %02h, required a5", loc_rdata); end
    endtask

    task automatic test_read_rs();
        logic ack, s;
        logic [7:0] b, exp;
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h03, ack); m_ptr = 4'h3;
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rd_ptr_ack: got %b, required 0", ack); end
        i2c_start();
        write_byte(8'hA1, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rd_addr_ack: got %b, required 0", ack); end
        rd_q.push_back(model_regs[m_ptr]);
        read_byte(1'b1, b);
        exp = rd_q.pop_front();
        checks++; if (b !== exp) begin errors++; $display("FAIL rd_byte: got %02h, required %02h", b, exp); end
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rd_release: got %b, required 0", sda_oe); end
        oe_seen = 1'b0;
        clk_bit(1'b1, s); clk_bit(1'b1, s);
        checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL rd_wait_stop_drive: got %b, required 0", oe_seen); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rd_busy_wait: got %b, required 1", busy); end
        i2c_stop();
        repeat (20) @(negedge HCLK);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy_after: got %b, required 0", busy); end
    endtask

    task automatic test_autoinc();
        logic ack;
        logic [7:0] b, exp, exp_f, exp_0;
`ifdef I2CT_AUTOINC_EN
        exp_f = 8'h11; exp_0 = 8'h22;
`else
        exp_f = 8'h22; exp_0 = 8'h00;
`endif
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h0F, ack); m_ptr = 4'hF;
        send_data(8'h11, ack);
        send_data(8'h22, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL ai_data_ack: got %b, required 0", ack); end
        i2c_stop();
        repeat (20) @(negedge HCLK);
        checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL ai_missing: got %0d pending, required 0", wr_q.size()); end
        loc_idx = 4'hF; #1;
        checks++; if (loc_rdata !== exp_f) begin errors++; $display("FAIL ai_regF: got %02h, required %02h", loc_rdata, exp_f); end
        loc_idx = 4'h0; #1;
        checks++; if (loc_rdata !== exp_0) begin errors++; $display("FAIL ai_reg0: got %02h, required %02h", loc_rdata, exp_0); end
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h0F, ack); m_ptr = 4'hF;
        i2c_start();
        write_byte(8'hA1, ack);
        rd_q.push_back(model_regs[m_ptr]);
        read_byte(1'b0, b);
        m_ptr = nxt(m_ptr);
        exp = rd_q.pop_front();
        checks++; if (b !== exp) begin errors++; $display("FAIL ai_rd0: got %02h, required %02h", b, exp); end
        rd_q.push_back(model_regs[m_ptr]);
        read_byte(1'b1, b);
        exp = rd_q.pop_front();
        checks++; if (b !== exp) begin errors++; $display("FAIL ai_rd1: got %02h, required %02h", b, exp); end
        i2c_stop();
        repeat (20) @(negedge HCLK);
    endtask

    task automatic test_addr_mismatch();
        logic ack;
        oe_seen = 1'b0; busy_seen = 1'b0;
        i2c_start();
        write_byte(8'hA2, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL nm_addr_ack: got %b, required 1", ack); end
        write_byte(8'h5A, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL nm_data_ack: got %b, required 1", ack); end
        i2c_stop();
        repeat (20) @(negedge HCLK);
        checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL nm_sda_driven: got %b, required 0", oe_seen); end
        checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL nm_busy: got %b, required 0", busy_seen); end
    endtask

    task automatic test_partial_stop();
        logic ack, s;
        logic [7:0] exp;
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h05, ack); m_ptr = 4'h5;
        clk_bit(1'b1, s); clk_bit(1'b0, s); clk_bit(1'b1, s); clk_bit(1'b1, s);
        i2c_stop();
        repeat (20) @(negedge HCLK);
        exp = model_regs[5];
        loc_idx = 4'h5; #1;
        checks++; if (loc_rdata !== exp) begin errors++; $display("FAIL ps_reg5_kept: got %02h, required %02h", loc_rdata, exp); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ps_busy: got %b, required 0", busy); end
        i2c_start();
        write_byte(8'hA0, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL ps_next_ack: got %b, required 0", ack); end
        write_byte(8'h05, ack); m_ptr = 4'h5;
        send_data(8'h3C, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL ps_data_ack: got %b, required 0", ack); end
        i2c_stop();
        repeat (20) @(negedge HCLK);
        loc_idx = 4'h5; #1;
        checks++; if (loc_rdata !== 8'h3C) begin errors++; $display("FAIL ps_reg5_new: got %02h, required 3c", loc_rdata); end
        checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL ps_missing: got %0d pending, required 0", wr_q.size()); end
    endtask

    task automatic test_reset_midread();
        logic ack;
        int n;
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h06, ack); m_ptr = 4'h6;
        send_data(8'h0F, ack);
        i2c_start();
        write_byte(8'hA1, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL hr_addr_ack: got %b, required 0", ack); end
        n = 0;
        while (sda_oe !== 1'b1 && n < 100) begin @(negedge HCLK); n++; end
        checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL hr_driving: got %b, required 1", sda_oe); end
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL hr_release: got %b, required 0", sda_oe); end
        @(negedge HCLK); @(negedge HCLK);
        HRESET = 1'b0;
        for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
        m_ptr = 4'd0;
        repeat (5) @(negedge HCLK);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hr_busy: got %b, required 0", busy); end
        loc_idx = 4'h6; #1;
        checks++; if (loc_rdata !== model_regs[6]) begin errors++; $display("FAIL hr_reg6: got %02h, required %02h", loc_rdata, model_regs[6]); end
        loc_idx = 4'h3; #1;
        checks++; if (loc_rdata !== 8'h00) begin errors++; $display("FAIL hr_reg3: got %02h, required 00", loc_rdata); end
        i2c_stop();
        i2c_start();
        write_byte(8'hA0, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL hr_next_ack: got %b, required 0", ack); end
        i2c_stop();
        repeat (20) @(negedge HCLK);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_rs();
        test_autoinc();
        test_addr_mismatch();
        test_partial_stop();
        test_reset_midread();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
